lif_neuron: RTL and testbench

Parametrised leaky integrate-and-fire neuron; next generation of the single-input accumulate-and-fire neuron. Adds:
- N_IN spike inputs, each with a signed weight (excitatory or inhibitory).
- Per-step linear leak, runtime threshold, saturating membrane.
- Refractory state machine.
Instantiated per neuron inside the SNN layer array; driven by the layer's time-step enable.

---
 rtl/lif_neuron.sv | 103 ++++++++++
 tb/tb_lif_neuron.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike inputs, linear leak, saturating membrane, refractory FSM.
// Define LIF_SOFT_RESET_EN for subtractive (residual-carrying) reset on fire; default is hard reset to 0.
module lif_neuron #(
  parameter int N_IN       = 4,
  parameter int W_W        = 8,
  parameter int ACC_W      = 12,
  parameter int REF_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_IN-1:0]     in_spikes,
  input  logic [N_IN*W_W-1:0] weights,
  input  logic [W_W-1:0]      leak,
  input  logic [ACC_W-1:0]    threshold,
  output logic                spike_out,
  output logic [ACC_W-1:0]    membrane,
  output logic                refractory
);
  // Wide enough for membrane + N_IN full-scale weights - leak without any overflow
  localparam int IW = ACC_W + W_W + $clog2(N_IN) + 2;
  localparam int CW = (REF_CYCLES > 0) ? $clog2(REF_CYCLES + 1) : 1;
  localparam logic [CW-1:0] REF_LOAD = CW'(REF_CYCLES);
  localparam logic signed [IW-1:0] VMAX = {{(IW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic {INTEGRATE, REFRACTORY} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [ACC_W-1:0]   mem_nx;
  logic               spk_nx;
  logic [N_IN-1:0][IW-1:0] terms;
  logic signed [IW-1:0]    sum, v;
  logic [ACC_W-1:0]   v_sat;
  logic               fire;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_term
    assign terms[gi] = in_spikes[gi] ? IW'(signed'(weights[gi*W_W +: W_W])) : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + signed'(terms[i]);
  end

  assign v = signed'(IW'(membrane)) + sum - signed'(IW'(leak));

  always_comb begin
    v_sat = v[ACC_W-1:0];
    if (v < 0)         v_sat = '0;
    else if (v > VMAX) v_sat = '1;
  end

  assign fire = (v_sat >= threshold);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mem_nx   = membrane;
    spk_nx   = 1'b0;
    if (en) begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            spk_nx = 1'b1;
`ifdef LIF_SOFT_RESET_EN
            mem_nx = v_sat - threshold;
`else
            mem_nx = '0;
`endif
            if (REF_CYCLES > 0) begin
              state_nx = REFRACTORY;
              cnt_nx   = REF_LOAD;
            end
          end else begin
            mem_nx = v_sat;
          end
        end
        REFRACTORY: begin
          cnt_nx = cnt - CW'(1);
          if (cnt == CW'(1)) state_nx = INTEGRATE;
        end
        default: state_nx = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INTEGRATE;
      cnt       <= '0;
      membrane  <= '0;
      spike_out <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      membrane  <= mem_nx;
      spike_out <= spk_nx;
    end
  end

  assign refractory = (state == REFRACTORY);
endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron (REF_CYCLES=3 main DUT, REF_CYCLES=0 side DUT).
module tb_lif_neuron;
`ifdef LIF_SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic        clk, rst_n, en;
  logic [3:0]  in_spikes;
  logic [31:0] weights;
  logic [7:0]  leak;
  logic [11:0] threshold, thr0;
  logic        spike_out, refractory, spk0, ref0;
  logic [11:0] membrane, mem0;
  int n_chk = 0, n_fail = 0;

  lif_neuron #(.N_IN(4), .W_W(8), .ACC_W(12), .REF_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_spikes(in_spikes), .weights(weights),
    .leak(leak), .threshold(threshold), .spike_out(spike_out), .membrane(membrane),
    .refractory(refractory));

  lif_neuron #(.N_IN(4), .W_W(8), .ACC_W(12), .REF_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_spikes(in_spikes), .weights(weights),
    .leak(leak), .threshold(thr0), .spike_out(spk0), .membrane(mem0),
    .refractory(ref0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weights = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endtask

  // One enabled step; returns 1 ns after the sampling edge
  task automatic step(input logic [3:0] s);
    in_spikes = s;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    in_spikes = '0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    in_spikes = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_spikes = '0; weights = '0; leak = '0;
    threshold = 12'd100; thr0 = 12'd0;
    #2;
    chk("rst_mem", membrane, 0);
    chk("rst_spk", spike_out, 0);
    chk("rst_ref", refractory, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Integrate to threshold, then refractory gating with strong input
    set_w(40, 0, 0, 0);
    step(4'b0001); chk("t1_mem1", membrane, 40);  chk("t1_spk1", spike_out, 0);
    step(4'b0001); chk("t1_mem2", membrane, 80);  chk("t1_spk2", spike_out, 0);
    step(4'b0001); chk("t1_spk3", spike_out, 1);  chk("t1_mem3", membrane, SOFT ? 20 : 0);
    chk("t1_ref3", refractory, 1);
    set_w(127, 127, 127, 127);
    for (int k = 1; k <= 3; k++) begin
      step(4'b1111);
      chk($sformatf("t4_ref%0d", k), refractory, (k < 3) ? 1 : 0);
      chk($sformatf("t4_mem%0d", k), membrane, SOFT ? 20 : 0);
      chk($sformatf("t4_spk%0d", k), spike_out, 0);
    end
    set_w(40, 0, 0, 0);
    step(4'b0001); chk("t4_post_mem", membrane, SOFT ? 60 : 40);
    chk("t4_post_ref", refractory, 0);

    // Inhibition floors at zero
    do_reset();
    set_w(10, -50, 0, 0);
    step(4'b0001); chk("t2_mem10", membrane, 10);
    step(4'b0010); chk("t2_floor", membrane, 0); chk("t2_nospk", spike_out, 0);

    // Saturation: 508 per step, ninth step exceeds 4095 and fires
    do_reset();
    set_w(127, 127, 127, 127);
    threshold = 12'd4095;
    for (int k = 1; k <= 8; k++) step(4'b1111);
    chk("t2_sat_mem8", membrane, 4064);
    chk("t2_sat_spk8", spike_out, 0);
    step(4'b1111);
    chk("t2_sat_spk", spike_out, 1);
    chk("t2_sat_mem", membrane, 0);

    // Linear leak
    do_reset();
    threshold = 12'd100;
    set_w(23, 0, 0, 0);
    step(4'b0001); chk("t3_mem23", membrane, 23);
    leak = 8'd5;
    begin
      int exp_l[6] = '{18, 13, 8, 3, 0, 0};
      for (int k = 0; k < 6; k++) begin
        step(4'b0000);
        chk($sformatf("t3_leak%0d", k), membrane, exp_l[k]);
      end
    end
    leak = 8'd0;

    // en low mid-refractory freezes the counter
    do_reset();
    set_w(127, 127, 127, 127);
    step(4'b0001); chk("t5_fire", spike_out, 1);
    step(4'b0000); chk("t5_ref_a", refractory, 1);
    in_spikes = 4'b1111;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_frz_ref", refractory, 1);
    chk("t5_frz_spk", spike_out, 0);
    chk("t5_frz_mem", membrane, SOFT ? 27 : 0);
    step(4'b0000); chk("t5_ref_b", refractory, 1);
    step(4'b0000); chk("t5_ref_c", refractory, 0);

    // Async reset while spiking and refractory
    do_reset();
    threshold = 12'd60;
    set_w(50, 0, 0, 0);
    step(4'b0001); chk("t6_mem50", membrane, 50);
    step(4'b0001); chk("t6_fire", spike_out, 1); chk("t6_ref", refractory, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_spk", spike_out, 0);
    chk("t6_async_ref", refractory, 0);
    chk("t6_async_mem", membrane, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001); chk("t6_post_mem", membrane, 50); chk("t6_post_ref", refractory, 0);

    // REF_CYCLES=0 with threshold 0: fires every enabled step, never refractory
    for (int k = 0; k < 3; k++) begin
      step(4'b0000);
      chk($sformatf("t6_r0_spk%0d", k), spk0, 1);
      chk($sformatf("t6_r0_ref%0d", k), ref0, 0);
    end
    @(posedge clk); #1;
    chk("t6_r0_idle", spk0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
